mem_arbiter: RTL and testbench

- Shares the single memory port between the CPU control FSM and a DMA requester (radio sample/packet engine).
- Sits between the CPU/DMA masters and the memory macro.
- Reproduces the CPU-side handshake exactly: active-low ce, busy rises then falls, valid marks read data. The control FSM therefore runs unchanged.
- Fixed CPU priority, with DMA anti-starvation and a busy-rise timeout.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the CPU, DMA and memory-side signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_ce_n;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_busy;
  logic              cpu_valid;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_gnt;
  logic [31:0]       dma_rdata;
  logic              dma_done;

  logic              mem_ce_n;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_busy;
  logic              mem_valid;

  logic              err;

  modport slave (
    input  cpu_ce_n, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_busy, cpu_valid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_done,
    output mem_ce_n, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_busy, mem_valid,
    output err
  );

  modport master (
    output cpu_ce_n, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_busy, cpu_valid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_done,
    input  mem_ce_n, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_busy, mem_valid,
    input  err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU control FSM and a DMA requester:
// fixed CPU priority, DMA anti-starvation and a busy-rise timeout.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic [31:0]       dma_rdata_q, dma_rdata_d;

  logic cpu_req;
  logic dma_req;
  logic active;

  assign cpu_req = !bus.cpu_ce_n;
  assign dma_req = bus.dma_req;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    err_d       = 1'b0;
    dma_rdata_d = dma_rdata_q;

    if (bus.mem_valid && owner_q == OWN_DMA) dma_rdata_d = bus.mem_rdata;

    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        // The CPU keeps priority unless the DMA has been passed over MAX_WAIT times.
        if (cpu_req && !(dma_req && wait_q == WAIT_MAX)) begin
          owner_d = OWN_CPU;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = ISSUE;
          if (dma_req) wait_d = wait_q + 1'b1;
        end else if (dma_req) begin
          owner_d = OWN_DMA;
          we_d    = bus.dma_we;
          addr_d  = bus.dma_addr;
          wdata_d = bus.dma_wdata;
          state_d = ISSUE;
          wait_d  = '0;
        end
      end
      ISSUE: begin
        if (bus.mem_busy) begin
          state_d = BUSY;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      BUSY: begin
        if (!bus.mem_busy) state_d = DONE;
      end
      DONE: begin
        // A request still asserted here is the tail of the finished one; never grant it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!dma_req) wait_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Strobes decode straight from the state flop so an asynchronous reset releases memory at once.
  assign active        = (state_q == ISSUE) || (state_q == BUSY);

  assign bus.mem_ce_n  = !active;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_busy  = active && owner_q == OWN_CPU && bus.mem_busy;
  assign bus.cpu_valid = owner_q == OWN_CPU && bus.mem_valid;
  assign bus.cpu_rdata = bus.mem_rdata;

  assign bus.dma_gnt   = active && owner_q == OWN_DMA;
  assign bus.dma_done  = state_q == DONE && owner_q == OWN_DMA;
  assign bus.dma_rdata = dma_rdata_q;

  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int MW = 2;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_ce_n  = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_req   = 1'b0;
    bus.dma_we    = 1'b0;
    bus.dma_addr  = '0;
    bus.dma_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_busy  = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    bus.cpu_ce_n = 1'b0;
    bus.dma_req  = 1'b1;
    bus.mem_busy = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL reset_mem_ce_n: got %b want 1", bus.mem_ce_n); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
    checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt: got %b want 0", bus.dma_gnt); end
    checks++; if (bus.dma_done !== 1'b0) begin errors++; $display("FAIL reset_dma_done: got %b want 0", bus.dma_done); end
    checks++; if (bus.dma_rdata !== '0) begin errors++; $display("FAIL reset_dma_rdata: got %h want 0", bus.dma_rdata); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL reset_cpu_busy: got %b want 0", bus.cpu_busy); end
    idle_inputs();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    tick();
    bus.cpu_ce_n = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    #1;
    checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL cpu_rd_latency: mem_ce_n got %b want 1 in request cycle", bus.mem_ce_n); end
    tick(); #1;
    checks++; if (bus.mem_ce_n !== 1'b0) begin errors++; $display("FAIL cpu_rd_issue: mem_ce_n got %b want 0", bus.mem_ce_n); end
    checks++; if (bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL cpu_rd_addr: got addr %h we %b want 40/0", bus.mem_addr, bus.mem_we); end
    for (int c = 2; c <= 4; c++) begin
      tick(); bus.mem_busy = 1'b1; #1;
      checks++; if (bus.cpu_busy !== 1'b1) begin errors++; $display("FAIL cpu_rd_busy_c%0d: got %b want 1", c, bus.cpu_busy); end
    end
    tick();
    bus.mem_busy = 1'b0; bus.mem_valid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.cpu_valid !== 1'b1 || bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL cpu_rd_valid: got valid %b busy %b want 1/0", bus.cpu_valid, bus.cpu_busy); end
    checks++; if (bus.cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rd_data: got %h want deadbeef", bus.cpu_rdata); end
    tick();
    bus.mem_valid = 1'b0; bus.cpu_ce_n = 1'b1;
    #1;
    checks++; if (bus.mem_ce_n !== 1'b1 || bus.dma_done !== 1'b0) begin errors++; $display("FAIL cpu_rd_done: got ce_n %b dma_done %b want 1/0", bus.mem_ce_n, bus.dma_done); end
    tick(); #1;
    checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL cpu_rd_idle: mem_ce_n got %b want 1", bus.mem_ce_n); end
  endtask

  task automatic test_dma_write();
    bit exp_gnt [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int n_done = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) begin
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h100; bus.dma_wdata = 32'h1234;
      end
      if (k == 2) bus.mem_busy = 1'b1;
      if (k == 3) bus.mem_busy = 1'b0;
      #1;
      if (bus.dma_done === 1'b1) n_done++;
      checks++; if (bus.dma_gnt !== exp_gnt[k]) begin errors++; $display("FAIL dma_wr_gnt_c%0d: got %b want %b", k, bus.dma_gnt, exp_gnt[k]); end
      if (k == 1) begin
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'h1234) begin
          errors++; $display("FAIL dma_wr_bus: got we %b addr %h wdata %h want 1/100/1234", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (k == 2) begin
        checks++; if (bus.cpu_busy !== 1'b0) begin errors++; $display("FAIL dma_wr_cpu_busy: got %b want 0", bus.cpu_busy); end
      end
      if (k == 4) begin
        checks++; if (bus.dma_done !== 1'b1) begin errors++; $display("FAIL dma_wr_done: got %b want 1", bus.dma_done); end
        bus.dma_req = 1'b0;
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL dma_wr_done_count: got %0d want 1", n_done); end
  endtask

  task automatic test_starvation();
    for (int r = 0; r < 3; r++) begin
      bit exp_dma = (r == 2);
      tick();
      bus.cpu_ce_n = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h300 + r;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h200;
      #1;
      tick(); #1;
      checks++; if (bus.dma_gnt !== exp_dma) begin errors++; $display("FAIL starve_gnt_r%0d: got %b want %b", r, bus.dma_gnt, exp_dma); end
      checks++; if (bus.mem_addr !== (exp_dma ? 32'h200 : 32'h300 + r)) begin errors++; $display("FAIL starve_addr_r%0d: got %h", r, bus.mem_addr); end
      tick(); bus.mem_busy = 1'b1; #1;
      checks++; if (bus.cpu_busy !== !exp_dma) begin errors++; $display("FAIL starve_cpu_busy_r%0d: got %b want %b", r, bus.cpu_busy, !exp_dma); end
      tick(); bus.mem_busy = 1'b0; bus.mem_valid = 1'b1; bus.mem_rdata = 32'hA5A50000 + r; #1;
      tick(); bus.mem_valid = 1'b0; #1;
      checks++; if (bus.dma_done !== exp_dma) begin errors++; $display("FAIL starve_done_r%0d: got %b want %b", r, bus.dma_done, exp_dma); end
      bus.cpu_ce_n = 1'b1;
      if (exp_dma) bus.dma_req = 1'b0;
    end
    checks++; if (bus.dma_rdata !== 32'hA5A50002) begin errors++; $display("FAIL starve_dma_rdata: got %h want a5a50002", bus.dma_rdata); end
    tick(); #1;
    checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL starve_idle: mem_ce_n got %b want 1", bus.mem_ce_n); end
  endtask

  task automatic test_timeout();
    int n_err = 0;
    int n_valid = 0;
    tick();
    bus.cpu_ce_n = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h80;
    #1;
    for (int k = 1; k <= 7; k++) begin
      tick(); #1;
      if (bus.err === 1'b1) n_err++;
      if (bus.cpu_valid === 1'b1) n_valid++;
      if (k == 1 + TO) begin
        checks++; if (bus.err !== 1'b1 || bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got err %b ce_n %b want 1/1", bus.err, bus.mem_ce_n); end
        bus.cpu_ce_n = 1'b1;
      end else if (k < 1 + TO) begin
        checks++; if (bus.mem_ce_n !== 1'b0) begin errors++; $display("FAIL timeout_issue_c%0d: mem_ce_n got %b want 0", k, bus.mem_ce_n); end
      end
    end
    checks++; if (n_err != 1) begin errors++; $display("FAIL timeout_err_count: got %0d want 1", n_err); end
    checks++; if (n_valid != 0) begin errors++; $display("FAIL timeout_cpu_valid: got %0d want 0", n_valid); end
    checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL timeout_idle: mem_ce_n got %b want 1", bus.mem_ce_n); end
  endtask

  task automatic test_held_request();
    tick();
    bus.cpu_ce_n = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h44;
    #1;
    tick();
    tick(); bus.mem_busy = 1'b1;
    tick(); bus.mem_busy = 1'b0;
    tick(); #1;
    checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL held_done: mem_ce_n got %b want 1", bus.mem_ce_n); end
    tick(); #1;
    checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL held_no_grant_in_done: mem_ce_n got %b want 1", bus.mem_ce_n); end
    tick(); #1;
    checks++; if (bus.mem_ce_n !== 1'b0 || bus.mem_addr !== 32'h44) begin errors++; $display("FAIL held_second_txn: got ce_n %b addr %h want 0/44", bus.mem_ce_n, bus.mem_addr); end
    tick(); bus.mem_busy = 1'b1;
    tick(); bus.mem_busy = 1'b0;
    tick(); #1;
    bus.cpu_ce_n = 1'b1;
    tick(); #1;
    tick(); #1;
    checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL held_released: mem_ce_n got %b want 1", bus.mem_ce_n); end
  endtask

  task automatic test_async_reset();
    int n_pulse = 0;
    tick();
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h500;
    #1;
    tick();
    tick(); bus.mem_busy = 1'b1; #1;
    tick(); #1;
    checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL areset_pre_gnt: got %b want 1", bus.dma_gnt); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.mem_ce_n !== 1'b1 || bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL areset_immediate: got ce_n %b gnt %b want 1/0", bus.mem_ce_n, bus.dma_gnt); end
    idle_inputs();
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      if (bus.dma_done === 1'b1 || bus.err === 1'b1 || bus.mem_ce_n !== 1'b1) n_pulse++;
    end
    checks++; if (n_pulse != 0) begin errors++; $display("FAIL areset_after: got %0d cycles with done/err/ce, want 0", n_pulse); end
  endtask

  task automatic test_random();
    bit          c_p = 1'b0, d_p = 1'b0;
    logic        c_we = 1'b0, d_we = 1'b0;
    logic [31:0] c_a = '0, c_wd = '0, d_a = '0, d_wd = '0;
    logic [31:0] exp_dr = '0;
    int          passes = 0;
    for (int r = 0; r < 60; r++) begin
      bit          win_dma, to, wdraw, new_c, new_d;
      logic        ewe;
      logic [31:0] ea, ewd, rd;
      int          lat, blen, exp_k, done_k;
      tick();
      new_c = !c_p && ($urandom_range(0, 1) == 1);
      new_d = !d_p && ($urandom_range(0, 1) == 1);
      if (!c_p && !d_p && !new_c && !new_d) new_c = 1'b1;
      if (new_c) begin c_p = 1'b1; c_we = 1'($urandom_range(0, 1)); c_a = $urandom; c_wd = $urandom; end
      if (new_d) begin d_p = 1'b1; d_we = 1'($urandom_range(0, 1)); d_a = $urandom; d_wd = $urandom; end
      bus.cpu_ce_n = !c_p; bus.cpu_we = c_we; bus.cpu_addr = c_a; bus.cpu_wdata = c_wd;
      bus.dma_req  = d_p;  bus.dma_we = d_we; bus.dma_addr = d_a; bus.dma_wdata = d_wd;
      #1;
      checks++; if (bus.mem_ce_n !== 1'b1) begin errors++; $display("FAIL rnd_idle_r%0d: mem_ce_n got %b want 1", r, bus.mem_ce_n); end

      // DMA wins if alone, or once it has been passed over MW times in a row.
      win_dma = (c_p && d_p) ? (passes == MW) : d_p;
      if (win_dma || !d_p) passes = 0;
      else if (passes < MW) passes++;
      ea  = win_dma ? d_a  : c_a;
      ewe = win_dma ? d_we : c_we;
      ewd = win_dma ? d_wd : c_wd;

      lat   = $urandom_range(0, TO + 1);
      blen  = $urandom_range(1, 3);
      to    = (lat >= TO);
      rd    = $urandom;
      wdraw = ($urandom_range(0, 3) == 0);
      exp_k = to ? TO : lat + blen + 1;
      done_k = -1;

      for (int k = 0; k < 40 && done_k < 0; k++) begin
        tick();
        bus.mem_busy  = !to && k >= lat && k < lat + blen;
        bus.mem_valid = !to && !ewe && k == lat + blen;
        bus.mem_rdata = bus.mem_valid ? rd : $urandom;
        if (k == 0 && wdraw) begin
          if (win_dma) begin d_p = 1'b0; bus.dma_req = 1'b0; bus.dma_addr = $urandom; end
          else begin c_p = 1'b0; bus.cpu_ce_n = 1'b1; bus.cpu_addr = $urandom; end
        end
        #1;
        if (bus.mem_ce_n === 1'b1) begin
          done_k = k;
          checks++; if (bus.err !== to) begin errors++; $display("FAIL rnd_err_r%0d: got %b want %b", r, bus.err, to); end
          checks++; if (bus.dma_done !== win_dma) begin errors++; $display("FAIL rnd_dma_done_r%0d: got %b want %b", r, bus.dma_done, win_dma); end
          if (win_dma) begin d_p = 1'b0; bus.dma_req = 1'b0; end
          else begin c_p = 1'b0; bus.cpu_ce_n = 1'b1; end
        end else begin
          checks++;
          if (bus.mem_addr !== ea || bus.mem_we !== ewe || bus.mem_wdata !== ewd ||
              bus.dma_gnt !== win_dma || bus.err !== 1'b0 || bus.dma_done !== 1'b0 ||
              bus.cpu_busy !== (!win_dma && bus.mem_busy) ||
              bus.cpu_valid !== (!win_dma && bus.mem_valid) ||
              (bus.cpu_valid === 1'b1 && bus.cpu_rdata !== rd)) begin
            errors++;
            $display("FAIL rnd_cycle_r%0d_k%0d: got addr %h we %b wdata %h gnt %b err %b done %b cbusy %b cvalid %b want addr %h we %b wdata %h gnt %b",
                     r, k, bus.mem_addr, bus.mem_we, bus.mem_wdata, bus.dma_gnt, bus.err, bus.dma_done,
                     bus.cpu_busy, bus.cpu_valid, ea, ewe, ewd, win_dma);
          end
        end
      end
      checks++; if (done_k != exp_k) begin errors++; $display("FAIL rnd_length_r%0d: done at %0d want %0d", r, done_k, exp_k); end
      if (win_dma && !to && !ewe) exp_dr = rd;
      checks++; if (bus.dma_rdata !== exp_dr) begin errors++; $display("FAIL rnd_dma_rdata_r%0d: got %h want %h", r, bus.dma_rdata, exp_dr); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_starvation();
    test_timeout();
    test_held_request();
    test_async_reset();
    test_random();
    idle_inputs();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
